switch_count_encoder: RTL

SWITCH_COUNT_ENCODER -- requirements
Module: switch_count_encoder

---
 rtl/led_bar_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/switch_count_encoder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/led_bar_pkg.sv
// Shared definitions for the switch count encoder and the LED bar decoder:
// FSM state encoding and the LED position range.
package led_bar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned LED_LOW  = 32'd4;
  localparam int unsigned LED_HIGH = 32'd9;
  localparam logic [3:0]  CODE_OFF = 4'b0000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; only q may feed logic.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Metastability stage followed by the clean output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      q      <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/switch_count_encoder.sv
// Debounces six slide switches and reports the committed position (4..9) as a
// 4-bit code with a one-cycle valid pulse; multi-hot patterns raise error.
module switch_count_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:4] sw,
  output logic [3:0] count,
  output logic       valid,
  output logic       error
);
  import led_bar_pkg::*;

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Position code of the highest set bit; only meaningful for one-hot or zero
  function automatic logic [3:0] encode(input logic [5:0] p);
    logic [3:0] code;
    code = CODE_OFF;
    for (int i = 0; i <= int'(LED_HIGH - LED_LOW); i++) begin
      code = p[i] ? 4'(LED_LOW + 32'(i)) : code;
    end
    return code;
  endfunction

  function automatic logic is_multi_hot(input logic [5:0] p);
    return (p & (p - 6'd1)) != 6'd0;
  endfunction

  logic [5:0]       sync_s;
  state_t           state_r, state_s;
  logic [5:0]       cand_r, cand_s;
  logic [5:0]       committed_r, committed_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       count_r, count_s;
  logic             valid_r, valid_s;
  logic             error_r, error_s;

  sync_2ff #(.WIDTH(6)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw),
    .q     (sync_s)
  );

  // State, debounce bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cand_r      <= 6'd0;
      committed_r <= 6'd0;
      cnt_r       <= {CNT_W{1'b0}};
      count_r     <= CODE_OFF;
      valid_r     <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cand_r      <= cand_s;
      committed_r <= committed_s;
      cnt_r       <= cnt_s;
      count_r     <= count_s;
      valid_r     <= valid_s;
      error_r     <= error_s;
    end
  end

  // Next state; output updates are computed on the edge that enters COMMIT
  always_comb begin
    state_s     = state_r;
    cand_s      = cand_r;
    committed_s = committed_r;
    cnt_s       = cnt_r;
    count_s     = count_r;
    valid_s     = 1'b0;
    error_s     = error_r;
    case (state_r)
      IDLE: begin
        if (sync_s != cand_r) begin
          cand_s  = sync_s;
          cnt_s   = {CNT_W{1'b0}};
          state_s = SETTLE;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (sync_s != cand_r) begin
          cand_s = sync_s;
          cnt_s  = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          state_s = COMMIT;
          // A pattern equal to the committed one is a silent re-confirmation
          if (cand_r != committed_r) begin
            committed_s = cand_r;
            if (is_multi_hot(cand_r)) begin
              error_s = 1'b1;
            end else begin
              count_s = encode(cand_r);
              error_s = 1'b0;
              valid_s = 1'b1;
            end
          end else begin
            committed_s = committed_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      COMMIT: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign count = count_r;
  assign valid = valid_r;
  assign error = error_r;

endmodule
